// File: rtl/cpu_ctrl.sv
// Hack CPU register and control stage: A/D/PC state, instruction decode,
// ALU operand and control generation, memory write and jump resolution.
module cpu_ctrl #(
   parameter int W  = 16,
   parameter int PW = 15
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   input  logic [W-1:0]  instr,
   input  logic [W-1:0]  in_m,
   output logic [W-1:0]  alu_x,
   output logic [W-1:0]  alu_y,
   output logic          zx,
   output logic          nx,
   output logic          zy,
   output logic          ny,
   output logic          f,
   output logic          no,
   input  logic [W-1:0]  alu_out,
   input  logic          zr,
   input  logic          ng,
   output logic [W-1:0]  out_m,
   output logic          write_m,
   output logic [PW-1:0] address_m,
   output logic [PW-1:0] pc
);

   logic [W-1:0]  a_q, a_d;
   logic [W-1:0]  d_q, d_d;
   logic [PW-1:0] pc_q, pc_d;

   logic       is_c;
   logic       a_bit;
   logic [2:0] dst;
   logic [2:0] jmp;
   logic       jump;

   assign is_c  = instr[W-1];
   assign a_bit = instr[12];
   assign dst   = instr[5:3];
   assign jmp   = instr[2:0];

   // A-instructions carry data in the low bits, so controls are forced to 0
   always_comb begin
      {zx, nx, zy, ny, f, no} = 6'b0;
      if (is_c) begin
         {zx, nx, zy, ny, f, no} = instr[11:6];
      end
   end

   assign jump = is_c & ((jmp[2] & ng) |
                         (jmp[1] & zr) |
                         (jmp[0] & ~zr & ~ng));

   assign alu_x     = d_q;
   assign alu_y     = (is_c && a_bit) ? in_m : a_q;
   assign out_m     = alu_out;
   assign write_m   = en & is_c & dst[0] & ~reset;
   assign address_m = a_q[PW-1:0];
   assign pc        = pc_q;

   always_comb begin
      a_d  = a_q;
      d_d  = d_q;
      pc_d = pc_q;
      if (reset) begin
         a_d  = '0;
         d_d  = '0;
         pc_d = '0;
      end else if (en) begin
         if (!is_c) begin
            a_d = {1'b0, instr[W-2:0]};
         end else begin
            if (dst[2]) a_d = alu_out;
            if (dst[1]) d_d = alu_out;
         end
         // jump target is the pre-edge A, even when A is also a destination
         pc_d = jump ? a_q[PW-1:0] : pc_q + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      a_q  <= a_d;
      d_q  <= d_d;
      pc_q <= pc_d;
   end

endmodule
